// File: rtl/device_c_pkg.sv
// device_c_pkg: shared constants and capture FSM state type for device_c
package device_c_pkg;
    localparam int WORD_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int FRAME_WORDS    = 4;
    typedef enum logic {IDLE, WAIT_DROP} state_e;
endpackage

// File: rtl/device_c_if.sv
// device_c_if: upstream capture, downstream pop and checksum signals of device_c
interface device_c_if #(parameter int WORD_W = device_c_pkg::WORD_W_DEF);
    logic              readyB;
    logic [WORD_W-1:0] in_B;
    logic              acceptedC;
    logic              takeC;
    logic [WORD_W-1:0] out_C;
    logic              validC;
    logic [WORD_W-1:0] frame_sum;
    logic              frame_done;
    modport master (output readyB, in_B, takeC, input acceptedC, out_C, validC, frame_sum, frame_done);
    modport slave  (input readyB, in_B, takeC, output acceptedC, out_C, validC, frame_sum, frame_done);
endinterface

// File: rtl/device_c_fifo.sv
// device_c_fifo: output word buffer with wrapping pointers and occupancy count
module device_c_fifo
    import device_c_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              valid,
    output logic              full
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign valid = count_q != '0;
    assign full  = count_q == CW'(FIFO_DEPTH);
    assign rdata = mem_q[rd_ptr_q];

    // full/empty guards use the registered count, so a same-cycle pop never frees room for a push
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && valid;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // storage and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/device_c_top.sv
// device_c_top: one-capture-per-readyB word buffer with optional 4-word frame checksum (DEVICE_C_CHECKSUM_EN)
module device_c_top
    import device_c_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    device_c_if.slave  bus
);
    state_e state_q, state_d;
    logic   accepted_q, accepted_d;
    logic   push, full;

    // capture once per readyB assertion, then wait for readyB to drop before re-arming
    always_comb begin
        push       = state_q == IDLE && bus.readyB && !full;
        state_d    = push ? WAIT_DROP : (state_q == WAIT_DROP && !bus.readyB) ? IDLE : state_q;
        accepted_d = push;
    end

    // capture FSM and acknowledge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            accepted_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            accepted_q <= accepted_d;
        end
    end

    assign bus.acceptedC = accepted_q;

    device_c_fifo #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.takeC),
        .wdata (bus.in_B),
        .rdata (bus.out_C),
        .valid (bus.validC),
        .full  (full)
    );

`ifdef DEVICE_C_CHECKSUM_EN
    localparam int FC_W = $clog2(FRAME_WORDS);
    logic [WORD_W-1:0] sum_acc_q, sum_acc_d, frame_sum_q, frame_sum_d;
    logic [FC_W-1:0]   wcnt_q, wcnt_d;
    logic              frame_done_q, frame_done_d;

    // accumulate captured words; the last word of a frame publishes the sum and restarts it
    always_comb begin
        sum_acc_d    = sum_acc_q;
        frame_sum_d  = frame_sum_q;
        wcnt_d       = wcnt_q;
        frame_done_d = 1'b0;
        if (push) begin
            wcnt_d = wcnt_q + FC_W'(1);
            if (wcnt_q == FC_W'(FRAME_WORDS - 1)) begin
                frame_sum_d  = sum_acc_q + bus.in_B;
                sum_acc_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                sum_acc_d = sum_acc_q + bus.in_B;
            end
        end
    end

    // checksum registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_acc_q    <= '0;
            frame_sum_q  <= '0;
            wcnt_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sum_acc_q    <= sum_acc_d;
            frame_sum_q  <= frame_sum_d;
            wcnt_q       <= wcnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.frame_sum  = frame_sum_q;
    assign bus.frame_done = frame_done_q;
`else
    assign bus.frame_sum  = '0;
    assign bus.frame_done = 1'b0;
`endif
endmodule
